// File: rtl/spi_slave_core_pkg.sv
// ----------------------------------------------------------------------------
// spi_slave_core_pkg
//   Shared definitions for the SPI slave endpoint:
//     - SPI mode constants (mode 0: CPOL=0, CPHA=0)
//     - FSM state encodings (ST_WAIT_SS, ST_IDLE, ST_SHIFT)
//     - RX FIFO depth (only present when SPI_SLAVE_RX_FIFO_EN is defined)
// ----------------------------------------------------------------------------
package spi_slave_core_pkg;

    localparam bit SPI_CPOL = 1'b0;
    localparam bit SPI_CPHA = 1'b0;

    typedef enum logic [1:0] {
        ST_WAIT_SS = 2'd0,
        ST_IDLE    = 2'd1,
        ST_SHIFT   = 2'd2
    } spi_state_t;

`ifdef SPI_SLAVE_RX_FIFO_EN
    localparam int RX_FIFO_DEPTH = 4;
`endif

endpackage

// File: rtl/spi_edge_sync.sv
// ----------------------------------------------------------------------------
// spi_edge_sync
//   Multi-flop synchronizer for one asynchronous SPI line, plus single-cycle
//   rise/fall pulses derived from the synchronized value and a one-cycle
//   delayed copy of it.
// Parameters
//   SYNC_STAGES  synchronizer depth (>= 2)
//   RST_VAL      value every flop takes during reset
// Ports
//   clk_i   in   system clock
//   reset   in   asynchronous, active-high reset
//   din     in   raw asynchronous input
//   dout    out  synchronized level
//   rise    out  1-cycle pulse on a 0->1 transition of dout
//   fall    out  1-cycle pulse on a 1->0 transition of dout
// ----------------------------------------------------------------------------
module spi_edge_sync #(
    parameter int SYNC_STAGES = 2,
    parameter bit RST_VAL     = 1'b0
) (
    input  logic clk_i,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign dout = sync_q[SYNC_STAGES-1];
    assign rise = dout & ~prev_q;
    assign fall = ~dout & prev_q;

endmodule

// File: rtl/spi_slave_core.sv
// ----------------------------------------------------------------------------
// spi_slave_core
//   SPI mode 0 slave endpoint, oversampled in the clk_i domain (clk_i must be
//   at least 8x SCK). Received words leave on an rx valid/ready stream, reply
//   words are taken from a tx valid/ready stream, MSB first.
// Configuration
//   SPI_SLAVE_RX_FIFO_EN  defined: 4-entry RX FIFO between shifter and rx port.
//                         undefined: single rx holding register.
// Ports
//   clk_i, reset            system clock, asynchronous active-high reset
//   spi_sck/ss/mosi         SPI lines from the router (ss active low)
//   spi_miso                reply bit (driven 0 outside a frame)
//   rx_data/valid/ready     received word stream
//   tx_data/valid/ready     reply word stream (tx_ready pulses on consumption)
//   frame_done              1-cycle pulse when SS deasserts during a frame
//   overrun / underrun      sticky error flags, cleared by err_clr
// ----------------------------------------------------------------------------
module spi_slave_core
    import spi_slave_core_pkg::*;
#(
    parameter int               DATA_W      = 8,
    parameter int               SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] TX_IDLE    = '0
) (
    input  logic              clk_i,
    input  logic              reset,
    input  logic              spi_sck,
    input  logic              spi_ss,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              frame_done,
    output logic              overrun,
    output logic              underrun,
    input  logic              err_clr
);

    localparam int               CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    logic ss_s, ss_rise, ss_fall;
    logic sck_s, sck_rise, sck_fall;
    logic mosi_s, mosi_rise, mosi_fall;

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
        .clk_i(clk_i), .reset(reset), .din(spi_ss),
        .dout(ss_s), .rise(ss_rise), .fall(ss_fall)
    );
    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
        .clk_i(clk_i), .reset(reset), .din(spi_sck),
        .dout(sck_s), .rise(sck_rise), .fall(sck_fall)
    );
    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk_i(clk_i), .reset(reset), .din(spi_mosi),
        .dout(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
    );

    // Only the SCK edges and the MOSI level are consumed.
    logic unused_sync;
    assign unused_sync = ^{sck_s, mosi_rise, mosi_fall};

    spi_state_t              state;
    logic [CNT_W-1:0]        bit_cnt;
    logic [SYNC_STAGES:0]    settle_q;
    logic                    word_done;
    logic [DATA_W-1:0]       rx_shift;
    logic [DATA_W-1:0]       tx_shift;

    logic sample_edge, drive_edge, in_shift, rx_shift_en, tx_shift_en, tx_load;

    // Mode 0/3 sample on rising SCK, modes 1/2 on falling.
    assign sample_edge = (SPI_CPOL ^ SPI_CPHA) ? sck_fall : sck_rise;
    assign drive_edge  = (SPI_CPOL ^ SPI_CPHA) ? sck_rise : sck_fall;

    assign in_shift    = (state == ST_SHIFT) && !ss_rise;
    assign rx_shift_en = in_shift && sample_edge;
    assign tx_shift_en = in_shift && drive_edge;
    // A tx word is pulled at frame start and at every word boundary.
    assign tx_load     = ((state == ST_IDLE) && ss_fall) ||
                         (tx_shift_en && (bit_cnt == '0));
    assign tx_ready    = tx_load && tx_valid;
    assign spi_miso    = (state == ST_SHIFT) ? tx_shift[DATA_W-1] : 1'b0;

    // Control: frame FSM, bit counter, status flags.
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            state      <= ST_WAIT_SS;
            bit_cnt    <= '0;
            settle_q   <= '0;
            word_done  <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            settle_q   <= {settle_q[SYNC_STAGES-1:0], 1'b1};
            word_done  <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= (underrun & ~err_clr) | (tx_load & ~tx_valid);
            case (state)
                // The ss synchronizer comes out of reset at 1 regardless of
                // the pin; wait until it has flushed so a reset with SS held
                // low cannot look like a fresh SS falling edge.
                ST_WAIT_SS: begin
                    if (settle_q[SYNC_STAGES] && ss_s)
                        state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (ss_fall) begin
                        state   <= ST_SHIFT;
                        bit_cnt <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (ss_rise) begin
                        state      <= ST_IDLE;
                        frame_done <= 1'b1;
                        bit_cnt    <= '0;
                    end else if (sample_edge) begin
                        bit_cnt   <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + CNT_W'(1);
                        word_done <= (bit_cnt == LAST_BIT);
                    end
                end
                default: state <= ST_WAIT_SS;
            endcase
        end
    end

    // Datapath shifters: every use is qualified by FSM state, so no reset.
    always_ff @(posedge clk_i) begin
        if (rx_shift_en)
            rx_shift <= {rx_shift[DATA_W-2:0], mosi_s};
        if (tx_load)
            tx_shift <= tx_valid ? tx_data : TX_IDLE;
        else if (tx_shift_en)
            tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
    end

`ifdef SPI_SLAVE_RX_FIFO_EN
    localparam int               PTR_W    = $clog2(RX_FIFO_DEPTH);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(RX_FIFO_DEPTH);

    logic [DATA_W-1:0] fifo_mem [RX_FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    fifo_cnt;
    logic              fifo_full, fifo_push, fifo_pop;

    assign fifo_full = (fifo_cnt == FULL_CNT);
    assign fifo_pop  = rx_valid && rx_ready;
    // A pop in the same cycle frees the slot the push needs.
    assign fifo_push = word_done && (!fifo_full || fifo_pop);
    assign rx_valid  = (fifo_cnt != '0);
    assign rx_data   = fifo_mem[rd_ptr];

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RX_FIFO_DEPTH; i++)
                fifo_mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            overrun  <= 1'b0;
        end else begin
            overrun <= (overrun & ~err_clr) | (word_done & ~fifo_push);
            if (fifo_push) begin
                fifo_mem[wr_ptr] <= rx_shift;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (fifo_pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_cnt <= fifo_cnt + (PTR_W + 1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (PTR_W + 1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end
`else
    logic rx_blocked;
    assign rx_blocked = rx_valid && !rx_ready;

    // Single holding register: a word landing while the previous one is
    // still unaccepted is dropped; one landing alongside rx_ready replaces it.
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            overrun <= (overrun & ~err_clr) | (word_done & rx_blocked);
            if (word_done && !rx_blocked) begin
                rx_data  <= rx_shift;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_spi_slave_core.sv
// ----------------------------------------------------------------------------
// tb_spi_slave_core
//   Directed bench for spi_slave_core in SPI mode 0. An SPI master task
//   drives SCK/SS/MOSI and captures MISO; received words are checked by a
//   scoreboard monitor against a queue of expected words pushed by stimulus.
// ----------------------------------------------------------------------------
module tb_spi_slave_core;

    localparam int HALF = 8;   // clk_i cycles per SCK half period

    logic       clk_i = 1'b0;
    logic       reset;
    logic       spi_sck, spi_ss, spi_mosi, spi_miso;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic       frame_done, overrun, underrun, err_clr;

    always #5 clk_i = ~clk_i;

    spi_slave_core #(.DATA_W(8), .SYNC_STAGES(2), .TX_IDLE(8'h00)) dut (
        .clk_i(clk_i), .reset(reset),
        .spi_sck(spi_sck), .spi_ss(spi_ss), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .frame_done(frame_done), .overrun(overrun), .underrun(underrun),
        .err_clr(err_clr)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_rx[$];
    logic [7:0] tx_q[$];
    int         tx_pulses = 0;
    int         rx_count  = 0;
    int         frame_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: compares each accepted rx word with the queue head.
    always @(negedge clk_i) begin
        if (frame_done) frame_cnt++;
        if (tx_ready && !tx_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL tx_ready_without_valid: tx_ready=1 with tx_valid=0");
        end
        if (!reset && rx_valid && rx_ready) begin
            rx_count++;
            if (exp_rx.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rx_unexpected: got 0x%0h, expected no word", rx_data);
            end else begin
                check("rx_data", {24'h0, rx_data}, {24'h0, exp_rx.pop_front()});
            end
        end
    end

    // Reply-word source: presents the head of tx_q and pops on handshake.
    initial begin
        bit hs;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        forever begin
            @(negedge clk_i);
            hs = tx_valid && tx_ready;
            @(posedge clk_i);
            #1;
            if (hs && tx_q.size() > 0) begin
                void'(tx_q.pop_front());
                tx_pulses++;
            end
            tx_valid = (tx_q.size() != 0);
            tx_data  = tx_valid ? tx_q[0] : 8'h00;
        end
    end

    task automatic sck_wait();
        repeat (HALF) @(posedge clk_i);
        #1;
    endtask

    task automatic spi_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = '0;
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_mosi = mo[i];
            sck_wait();
            mi[i]   = spi_miso;
            spi_sck = 1'b1;
            sck_wait();
            spi_sck = 1'b0;
        end
    endtask

    task automatic ss_begin();
        spi_ss = 1'b0;
        sck_wait();
    endtask

    task automatic ss_end();
        sck_wait();
        spi_ss = 1'b1;
        sck_wait();
        sck_wait();
    endtask

    task automatic pulse_err_clr();
        @(posedge clk_i); #1;
        err_clr = 1'b1;
        @(posedge clk_i); #1;
        err_clr = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int guard = 0;
        while (exp_rx.size() != 0 && guard < 500) begin
            @(posedge clk_i);
            guard++;
        end
        #1;
        check(name, exp_rx.size(), 0);
    endtask

    initial begin
        logic [7:0] mi;
        int r0, f0, t0;

        reset = 1'b1; spi_sck = 1'b0; spi_ss = 1'b1; spi_mosi = 1'b0;
        rx_ready = 1'b0; err_clr = 1'b0;
        repeat (3) @(posedge clk_i); #1;
        check("rst_rx_valid",   rx_valid,   0);
        check("rst_rx_data",    rx_data,    0);
        check("rst_overrun",    overrun,    0);
        check("rst_underrun",   underrun,   0);
        check("rst_frame_done", frame_done, 0);
        check("rst_tx_ready",   tx_ready,   0);
        check("rst_miso",       spi_miso,   0);
        reset = 1'b0;
        repeat (10) @(posedge clk_i); #1;

        // 1: single word with a reply word available
        rx_ready = 1'b1;
        tx_q.push_back(8'h3C);
        exp_rx.push_back(8'hA5);
        r0 = rx_count; f0 = frame_cnt; t0 = tx_pulses;
        ss_begin();
        spi_bits(8'hA5, 8, mi); check("t1_miso", mi, 8'h3C);
        ss_end();
        wait_drain("t1_rx_drain");
        check("t1_rx_count",   rx_count - r0,  1);
        check("t1_frame_done", frame_cnt - f0, 1);
        check("t1_tx_ready",   tx_pulses - t0, 1);

        // 2: three-word burst in one frame
        tx_q.push_back(8'h11); tx_q.push_back(8'h22); tx_q.push_back(8'h33);
        exp_rx.push_back(8'h01); exp_rx.push_back(8'h02); exp_rx.push_back(8'h03);
        r0 = rx_count; f0 = frame_cnt; t0 = tx_pulses;
        ss_begin();
        spi_bits(8'h01, 8, mi); check("t2_miso0", mi, 8'h11);
        spi_bits(8'h02, 8, mi); check("t2_miso1", mi, 8'h22);
        spi_bits(8'h03, 8, mi); check("t2_miso2", mi, 8'h33);
        ss_end();
        wait_drain("t2_rx_drain");
        check("t2_rx_count",   rx_count - r0,  3);
        check("t2_tx_ready",   tx_pulses - t0, 3);
        check("t2_frame_done", frame_cnt - f0, 1);

        // 3: consumer stalled -> overrun
        rx_ready = 1'b0;
        r0 = rx_count;
        ss_begin();
`ifdef SPI_SLAVE_RX_FIFO_EN
        for (int w = 1; w <= 5; w++) begin
            if (w <= 4) exp_rx.push_back(8'(w));
            spi_bits(8'(w), 8, mi);
        end
`else
        exp_rx.push_back(8'h01);
        spi_bits(8'h01, 8, mi);
        spi_bits(8'h02, 8, mi);
`endif
        ss_end();
        check("t3_rx_valid_held", rx_valid, 1);
        check("t3_rx_data_held",  rx_data,  8'h01);
        check("t3_overrun_set",   overrun,  1);
        pulse_err_clr();
        check("t3_overrun_clr",   overrun,  0);
        rx_ready = 1'b1;
        wait_drain("t3_rx_drain");
`ifdef SPI_SLAVE_RX_FIFO_EN
        check("t3_rx_count", rx_count - r0, 4);
`else
        check("t3_rx_count", rx_count - r0, 1);
`endif

        // 4: no reply words -> TX_IDLE and underrun
        pulse_err_clr();
        check("t4_underrun_clr", underrun, 0);
        exp_rx.push_back(8'h96); exp_rx.push_back(8'h69);
        t0 = tx_pulses;
        ss_begin();
        spi_bits(8'h96, 8, mi); check("t4_miso0", mi, 8'h00);
        spi_bits(8'h69, 8, mi); check("t4_miso1", mi, 8'h00);
        ss_end();
        check("t4_underrun_set", underrun, 1);
        check("t4_tx_ready",     tx_pulses - t0, 0);
        wait_drain("t4_rx_drain");

        // 5: aborted partial word, then a full frame
        r0 = rx_count;
        ss_begin();
        spi_bits(8'hFF, 5, mi);
        ss_end();
        check("t5_no_rx_valid", rx_valid, 0);
        check("t5_partial_cnt", rx_count - r0, 0);
        exp_rx.push_back(8'hC3);
        ss_begin();
        spi_bits(8'hC3, 8, mi);
        ss_end();
        wait_drain("t5_rx_drain");
        check("t5_rx_count", rx_count - r0, 1);

        // 6: reset mid-frame with SS held low
        r0 = rx_count;
        ss_begin();
        spi_bits(8'hFF, 3, mi);
        reset = 1'b1;
        repeat (3) @(posedge clk_i); #1;
        reset = 1'b0;
        f0 = frame_cnt;
        check("t6_rst_underrun", underrun, 0);
        spi_bits(8'hFF, 4, mi);
        check("t6_no_rx_valid", rx_valid, 0);
        ss_end();
        check("t6_no_frame_done", frame_cnt - f0, 0);
        check("t6_no_start",      underrun,       0);
        check("t6_no_rx_word",    rx_count - r0,  0);
        exp_rx.push_back(8'h5A);
        ss_begin();
        spi_bits(8'h5A, 8, mi);
        ss_end();
        wait_drain("t6_rx_drain");
        check("t6_rx_count",   rx_count - r0,  1);
        check("t6_frame_done", frame_cnt - f0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not complete within time limit");
        $fatal(1, "timeout");
    end

endmodule
